// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial wide adder: the slice width of the
// 4-bit adder it drives and the controller state encoding.
package nibble_serial_adder_pkg;

    // Width of one slice handled by the ripple-carry adder per cycle.
    localparam int NIB_W = 4;

    // Controller states: waiting for operands, stepping through nibbles,
    // holding the result until the consumer takes it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_rca.sv
// 4-bit ripple-carry adder: the single slice reused every cycle by
// nibble_serial_adder. Purely combinational.
module bit_ripple_carry_adder
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIB_W-1:0] A,
    input  logic [NIB_W-1:0] B,
    input  logic             Cin,
    output logic [NIB_W-1:0] Sum,
    output logic             Cout
);

    logic [NIB_W:0] c;

    // Full-adder chain, carry rippling from bit 0 upward.
    always_comb begin
        c    = '0;
        Sum  = '0;
        c[0] = Cin;
        for (int i = 0; i < NIB_W; i++) begin
            Sum[i]   = A[i] ^ B[i] ^ c[i];
            c[i + 1] = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i]);
        end
        Cout = c[NIB_W];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder. An accepted operand pair is pushed through one
// 4-bit ripple-carry adder a nibble per cycle, LSB first, with the inter-nibble
// carry held in a register. The result is returned over a valid/ready
// handshake; a new pair is only accepted once the previous result retired.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int WIDTH   = NIB_W * NIBBLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    // One spare bit so the counter can always represent NIBBLES-1, also for
    // NIBBLES=1 where $clog2 yields 0.
    localparam int IDX_W = $clog2(NIBBLES) + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic             carry_p0;
    logic [IDX_W-1:0] idx;

    logic             accept;
    logic             last_nib;
    logic [NIB_W-1:0] nib_a;
    logic [NIB_W-1:0] nib_b;
    logic [NIB_W-1:0] nib_sum;
    logic             nib_cout;

    // Extract nibble i of v; a shift keeps the select in range for any idx.
    function automatic logic [NIB_W-1:0] nibble_at(input logic [WIDTH-1:0] v,
                                                   input logic [IDX_W-1:0] i);
        logic [WIDTH-1:0] s;
        s = v >> (NIB_W * i);
        return s[NIB_W-1:0];
    endfunction

    // Return v with nibble i replaced by n, all other bits untouched.
    function automatic logic [WIDTH-1:0] nibble_put(input logic [WIDTH-1:0] v,
                                                    input logic [IDX_W-1:0] i,
                                                    input logic [NIB_W-1:0] n);
        logic [WIDTH-1:0] mask;
        logic [WIDTH-1:0] data;
        mask = WIDTH'({NIB_W{1'b1}}) << (NIB_W * i);
        data = WIDTH'(n) << (NIB_W * i);
        return (v & ~mask) | (data & mask);
    endfunction

    // Handshake and slice selection decoded from the registered state.
    always_comb begin
        accept   = (state == IDLE) && in_valid && in_ready;
        last_nib = (idx == LAST_IDX);
        nib_a    = nibble_at(a_p0, idx);
        nib_b    = nibble_at(b_p0, idx);
    end

    bit_ripple_carry_adder u_rca (
        .A   (nib_a),
        .B   (nib_b),
        .Cin (carry_p0),
        .Sum (nib_sum),
        .Cout(nib_cout)
    );

    // Operand capture at the accept edge only; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0 <= in_a;
            b_p0 <= in_b;
        end
    end

    // Controller: accept, step one nibble per RUN cycle, hold result in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            carry_p0  <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        carry_p0 <= in_cin;
                        idx      <= '0;
                        out_sum  <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    out_sum  <= nibble_put(out_sum, idx, nib_sum);
                    carry_p0 <= nib_cout;
                    if (last_nib) begin
                        out_cout  <= nib_cout;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: a 4-nibble instance driven through directed
// cases, backpressure, mid-transaction reset and random traffic against an
// A+B+cin scoreboard, plus a 1-nibble instance for the degenerate case.
module tb_nibble_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [3:0]  s_in_a;
    logic [3:0]  s_in_b;
    logic        s_in_cin;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [3:0]  s_out_sum;
    logic        s_out_cout;

    int total  = 0;
    int passed = 0;
    logic [16:0] exp_q[$];

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout)
    );

    nibble_serial_adder #(.NIBBLES(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (s_in_valid),
        .in_ready (s_in_ready),
        .in_a     (s_in_a),
        .in_b     (s_in_b),
        .in_cin   (s_in_cin),
        .out_valid(s_out_valid),
        .out_ready(s_out_ready),
        .out_sum  (s_out_sum),
        .out_cout (s_out_cout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction on the 4-nibble instance; stall = DONE cycles with
    // out_ready low, pulse = drive in_valid during those stalls.
    task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic cin,
                           input int stall, input bit pulse);
        int k;
        logic [15:0] hold_sum;
        logic        hold_cout;
        logic [16:0] e;
        k = 0;
        while (!in_ready && k < 20) begin
            step();
            k++;
        end
        check("ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        exp_q.push_back(17'(a) + 17'(b) + 17'(cin));
        step();
        in_valid = 1'b0;
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
        in_cin   = 1'($urandom);
        k = 0;
        while (!out_valid && k < 20) begin
            step();
            k++;
        end
        check("latency", 32'(k), 32'd4);
        hold_sum  = out_sum;
        hold_cout = out_cout;
        for (int i = 0; i < stall; i++) begin
            if (pulse) in_valid = 1'b1;
            step();
            check("stall_sum", 32'(out_sum), 32'(hold_sum));
            check("stall_cout", 32'(out_cout), 32'(hold_cout));
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("result", 32'({out_cout, out_sum}), 32'(e));
        end else begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
        end
        step();
        out_ready = 1'b0;
        check("retire_out_valid", 32'(out_valid), 32'd0);
        check("retire_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int k;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_a        = '0;
        in_b        = '0;
        in_cin      = 1'b0;
        out_ready   = 1'b0;
        s_in_valid  = 1'b0;
        s_in_a      = '0;
        s_in_b      = '0;
        s_in_cin    = 1'b0;
        s_out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_cout", 32'(out_cout), 32'd0);
        check("rst1_in_ready", 32'(s_in_ready), 32'd1);
        check("rst1_out_valid", 32'(s_out_valid), 32'd0);
        check("rst1_out_sum", 32'(s_out_sum), 32'd0);
        check("rst1_out_cout", 32'(s_out_cout), 32'd0);

        run_txn(16'h0000, 16'h0000, 1'b0, 0, 1'b0);
        run_txn(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        run_txn(16'h1234, 16'h4321, 1'b1, 0, 1'b0);
        run_txn(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0);
        run_txn(16'hBEEF, 16'h1111, 1'b0, 3, 1'b1);

        // Reset while the third nibble is pending discards the transaction.
        in_valid = 1'b1;
        in_a     = 16'h1234;
        in_b     = 16'h4321;
        in_cin   = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("run_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_sum", 32'(out_sum), 32'd0);
        run_txn(16'h0001, 16'h0001, 1'b0, 0, 1'b0);

        // Single-nibble instance: one RUN cycle then DONE.
        s_in_valid = 1'b1;
        s_in_a     = 4'hA;
        s_in_b     = 4'h5;
        s_in_cin   = 1'b1;
        step();
        s_in_valid = 1'b0;
        k = 0;
        while (!s_out_valid && k < 10) begin
            step();
            k++;
        end
        check("n1_latency", 32'(k), 32'd1);
        check("n1_sum", 32'(s_out_sum), 32'h0);
        check("n1_cout", 32'(s_out_cout), 32'd1);
        s_out_ready = 1'b1;
        step();
        s_out_ready = 1'b0;
        check("n1_retire", 32'(s_out_valid), 32'd0);

        for (int n = 0; n < 1000; n++) begin
            run_txn(16'($urandom), 16'($urandom), 1'($urandom),
                    int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
        end

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
